// File: rtl/muldiv_if.sv
// Handshake and result bundle between the pipeline control and the
// iterative multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div0;

    modport master (
        output start, funct, a, b, cancel,
        input  busy, done, hi, lo, div0
    );

    modport slave (
        input  start, funct, a, b, cancel,
        output busy, done, hi, lo, div0
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Radix-2 shift-add multiply and restoring divide run on magnitudes; the
// signs are fixed up in a single FIX cycle before HI/LO are written.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Two's-complement negation at operand width
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation at product width
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of an operand when the operation is signed, raw value otherwise
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] r;
        if (sgn && v[WIDTH-1]) begin
            r = neg_w(v);
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [1:0]         state_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] acc_r;      // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   op_r;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_raw_r;    // dividend as issued, returned in HI on divide by zero
    logic               mul_r;
    logic               neg_q_r;    // product / quotient needs negation
    logic               neg_r_r;    // remainder needs negation
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;
    logic               div0_r;

    logic               is_md_s;
    logic               is_mul_s;
    logic               is_sgn_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic               div_zero_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    // Decode the funct field into operation class
    always_comb begin
        is_md_s  = 1'b0;
        is_mul_s = 1'b0;
        is_sgn_s = 1'b0;
        case (bus.funct)
            FN_MULT: begin
                is_md_s  = 1'b1;
                is_mul_s = 1'b1;
                is_sgn_s = 1'b1;
            end
            FN_MULTU: begin
                is_md_s  = 1'b1;
                is_mul_s = 1'b1;
            end
            FN_DIV: begin
                is_md_s  = 1'b1;
                is_sgn_s = 1'b1;
            end
            FN_DIVU: begin
                is_md_s  = 1'b1;
            end
            default: begin
                is_md_s  = 1'b0;
            end
        endcase
    end

    assign a_mag_s = mag(bus.a, is_sgn_s);
    assign b_mag_s = mag(bus.b, is_sgn_s);

    // One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        div_shift_s = acc_r[2*WIDTH-1:WIDTH-1];
        div_trial_s = div_shift_s - {1'b0, op_r};
        acc_next_s  = acc_r;
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, op_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        if (mul_r) begin
            acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end else if (!div_trial_s[WIDTH]) begin
            acc_next_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            acc_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction and divide-by-zero substitution for the FIX cycle
    always_comb begin
        div_zero_s = !mul_r && (op_r == {WIDTH{1'b0}});
        prod_s     = acc_r;
        res_hi_s   = acc_r[2*WIDTH-1:WIDTH];
        res_lo_s   = acc_r[WIDTH-1:0];
        if (mul_r) begin
            if (neg_q_r) begin
                prod_s = neg_2w(acc_r);
            end else begin
                prod_s = acc_r;
            end
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end else if (div_zero_s) begin
            res_hi_s = a_raw_r;
            res_lo_s = {WIDTH{1'b1}};
        end else begin
            if (neg_q_r) begin
                res_lo_s = neg_w(acc_r[WIDTH-1:0]);
            end else begin
                res_lo_s = acc_r[WIDTH-1:0];
            end
            if (neg_r_r) begin
                res_hi_s = neg_w(acc_r[2*WIDTH-1:WIDTH]);
            end else begin
                res_hi_s = acc_r[2*WIDTH-1:WIDTH];
            end
        end
    end

    // Control FSM, iteration datapath and HI/LO/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            acc_r   <= '0;
            op_r    <= '0;
            a_raw_r <= '0;
            mul_r   <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            done_r  <= 1'b0;
            div0_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        if (is_md_s) begin
                            state_r <= ST_RUN;
                            cnt_r   <= CNT_LAST;
                            mul_r   <= is_mul_s;
                            a_raw_r <= bus.a;
                            neg_q_r <= is_sgn_s && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_r_r <= is_sgn_s && bus.a[WIDTH-1];
                            div0_r  <= 1'b0;
                            if (is_mul_s) begin
                                acc_r <= {{WIDTH{1'b0}}, b_mag_s};
                                op_r  <= a_mag_s;
                            end else begin
                                acc_r <= {{WIDTH{1'b0}}, a_mag_s};
                                op_r  <= b_mag_s;
                            end
                        end else if (bus.funct == FN_MTHI) begin
                            hi_r <= bus.a;
                        end else if (bus.funct == FN_MTLO) begin
                            lo_r <= bus.a;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.cancel) begin
                        state_r <= ST_IDLE;
                    end else begin
                        acc_r <= acc_next_s;
                        if (cnt_r == '0) begin
                            state_r <= ST_FIX;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                end
                ST_FIX: begin
                    state_r <= ST_IDLE;
                    if (!bus.cancel) begin
                        hi_r   <= res_hi_s;
                        lo_r   <= res_lo_s;
                        done_r <= 1'b1;
                        div0_r <= div_zero_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state_r != ST_IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.div0 = div0_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a 32-bit and an 8-bit instance,
// expected HI/LO/div0 queued at issue and compared when done pulses.
module tb_muldiv_unit;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb32[$];
    logic [15:0] sb8[$];

    muldiv_if #(.WIDTH(32)) bus32 ();
    muldiv_if #(.WIDTH(8))  bus8 ();

    muldiv_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    muldiv_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural reference built on 64-bit arithmetic
    function automatic exp_t model32(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        logic signed [63:0] sa, sb, sr;
        logic [63:0] ua, ub, ur;
        sa = {{32{av[31]}}, av};
        sb = {{32{bv[31]}}, bv};
        ua = {32'd0, av};
        ub = {32'd0, bv};
        e.div0 = 1'b0;
        e.hi = 32'd0;
        e.lo = 32'd0;
        if (f == F_MULT) begin
            sr = sa * sb;
            e.hi = sr[63:32]; e.lo = sr[31:0];
        end else if (f == F_MULTU) begin
            ur = ua * ub;
            e.hi = ur[63:32]; e.lo = ur[31:0];
        end else if (bv == 32'd0) begin
            e.hi = av; e.lo = 32'hFFFF_FFFF; e.div0 = 1'b1;
        end else if (f == F_DIV) begin
            sr = sa / sb; e.lo = sr[31:0];
            sr = sa % sb; e.hi = sr[31:0];
        end else begin
            ur = ua / ub; e.lo = ur[31:0];
            ur = ua % ub; e.hi = ur[31:0];
        end
        return e;
    endfunction

    task automatic do_op32(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] eh, input logic [31:0] el, input logic ed,
                           input string nm);
        exp_t e;
        int busy_cnt;
        int cyc;
        @(negedge clk);
        bus32.start = 1'b1; bus32.funct = f; bus32.a = av; bus32.b = bv;
        e.hi = eh; e.lo = el; e.div0 = ed;
        sb32.push_back(e);
        @(negedge clk);
        bus32.start = 1'b0;
        checks++;
        if (bus32.busy !== 1'b1 || bus32.div0 !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b div0=%b, required busy=1 div0=0", nm, bus32.busy, bus32.div0);
        end
        busy_cnt = 0;
        cyc = 0;
        while (bus32.done !== 1'b1 && cyc < 200) begin
            if (bus32.busy === 1'b1) busy_cnt++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (bus32.done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done never pulsed within %0d cycles", nm, cyc);
        end else begin
            e = sb32.pop_front();
            checks++;
            if (busy_cnt != 33 || bus32.busy !== 1'b0) begin
                errors++;
                $display("FAIL %s latency: busy cycles=%0d busy_in_done=%b, required 33 and 0", nm, busy_cnt, bus32.busy);
            end
            checks++;
            if (bus32.hi !== e.hi || bus32.lo !== e.lo || bus32.div0 !== e.div0) begin
                errors++;
                $display("FAIL %s result: hi=%h lo=%h div0=%b, required hi=%h lo=%h div0=%b",
                         nm, bus32.hi, bus32.lo, bus32.div0, e.hi, e.lo, e.div0);
            end
            @(negedge clk);
            checks++;
            if (bus32.done !== 1'b0) begin
                errors++;
                $display("FAIL %s done_width: done=%b one cycle later, required 0", nm, bus32.done);
            end
        end
    endtask

    task automatic mt32(input logic [5:0] f, input logic [31:0] av);
        @(negedge clk);
        bus32.start = 1'b1; bus32.funct = f; bus32.a = av;
        @(negedge clk);
        bus32.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus32.hi !== 32'd0 || bus32.lo !== 32'd0 || bus32.busy !== 1'b0 ||
            bus32.done !== 1'b0 || bus32.div0 !== 1'b0 || bus8.busy !== 1'b0 ||
            bus8.hi !== 8'd0 || bus8.lo !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b div0=%b, required all zero",
                     bus32.hi, bus32.lo, bus32.busy, bus32.done, bus32.div0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_multu_max();
        do_op32(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    endtask

    task automatic test_signed();
        do_op32(F_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg3x7");
        do_op32(F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg7by2");
        do_op32(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, "div_minneg");
    endtask

    task automatic test_div0();
        do_op32(F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, "divu_by_zero");
        do_op32(F_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, "multu_after_div0");
        do_op32(F_DIV, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1, "div_neg_by_zero");
    endtask

    task automatic test_random();
        logic [5:0] fl [4];
        logic [31:0] av, bv;
        exp_t e;
        fl[0] = F_MULT; fl[1] = F_MULTU; fl[2] = F_DIV; fl[3] = F_DIVU;
        for (int i = 0; i < 8; i++) begin
            av = $urandom;
            if (i >= 4) bv = $urandom_range(1, 1000);
            else bv = $urandom;
            if (i == 6) bv = 32'hFFFF_FFF9;
            e = model32(fl[i % 4], av, bv);
            do_op32(fl[i % 4], av, bv, e.hi, e.lo, e.div0, "random");
        end
    endtask

    task automatic test_mthi();
        mt32(F_MTHI, 32'h0000_1234);
        checks++;
        if (bus32.hi !== 32'h0000_1234 || bus32.busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h busy=%b, required hi=00001234 busy=0", bus32.hi, bus32.busy);
        end
        mt32(F_MTLO, 32'h0000_5678);
        checks++;
        if (bus32.lo !== 32'h0000_5678 || bus32.busy !== 1'b0 || bus32.hi !== 32'h0000_1234) begin
            errors++;
            $display("FAIL mtlo: lo=%h hi=%h busy=%b, required lo=00005678 hi=00001234 busy=0",
                     bus32.lo, bus32.hi, bus32.busy);
        end
    endtask

    task automatic test_cancel();
        int seen_done;
        // unsupported funct is ignored
        mt32(6'b100000, 32'hDEAD_BEEF);
        checks++;
        if (bus32.busy !== 1'b0 || bus32.hi !== 32'h0000_1234 || bus32.lo !== 32'h0000_5678) begin
            errors++;
            $display("FAIL bad_funct: busy=%b hi=%h lo=%h, required 0 00001234 00005678",
                     bus32.busy, bus32.hi, bus32.lo);
        end
        @(negedge clk);
        bus32.start = 1'b1; bus32.funct = F_MULT; bus32.a = 32'h1234; bus32.b = 32'h10;
        @(negedge clk);
        bus32.start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (c == 5) begin
                bus32.start = 1'b1; bus32.funct = F_MTHI; bus32.a = 32'hDEAD_0000;
            end else begin
                bus32.start = 1'b0;
            end
            @(negedge clk);
        end
        bus32.start = 1'b0;
        checks++;
        if (bus32.busy !== 1'b1) begin
            errors++;
            $display("FAIL cancel_pre: busy=%b on 10th busy cycle, required 1", bus32.busy);
        end
        bus32.cancel = 1'b1;
        @(negedge clk);
        bus32.cancel = 1'b0;
        checks++;
        if (bus32.busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_busy: busy=%b after cancel, required 0", bus32.busy);
        end
        seen_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus32.done === 1'b1) seen_done++;
            @(negedge clk);
        end
        checks++;
        if (seen_done != 0 || bus32.hi !== 32'h0000_1234 || bus32.lo !== 32'h0000_5678) begin
            errors++;
            $display("FAIL cancel_regs: done_pulses=%0d hi=%h lo=%h, required 0 00001234 00005678",
                     seen_done, bus32.hi, bus32.lo);
        end
    endtask

    task automatic test_reset_mid();
        mt32(F_MTHI, 32'h0000_AAAA);
        mt32(F_MTLO, 32'h0000_5555);
        @(negedge clk);
        bus32.start = 1'b1; bus32.funct = F_DIVU; bus32.a = 32'd1000; bus32.b = 32'd3;
        @(negedge clk);
        bus32.start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus32.hi !== 32'd0 || bus32.lo !== 32'd0 || bus32.busy !== 1'b0 ||
            bus32.done !== 1'b0 || bus32.div0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b div0=%b, required all zero",
                     bus32.hi, bus32.lo, bus32.busy, bus32.done, bus32.div0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op32(F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_after_reset");
    endtask

    task automatic test_back_to_back();
        int busy_cnt;
        int cyc;
        logic [15:0] e;
        @(negedge clk);
        bus8.start = 1'b1; bus8.funct = F_MULT; bus8.a = 8'h80; bus8.b = 8'h80;
        sb8.push_back({8'h40, 8'h00});
        sb8.push_back({8'd2, 8'd22});
        for (int op = 0; op < 2; op++) begin
            @(negedge clk);
            bus8.start = 1'b0;
            busy_cnt = 0;
            cyc = 0;
            while (bus8.done !== 1'b1 && cyc < 50) begin
                if (bus8.busy === 1'b1) busy_cnt++;
                cyc++;
                @(negedge clk);
            end
            checks++;
            if (bus8.done !== 1'b1) begin
                errors++;
                $display("FAIL narrow_timeout op%0d: done never pulsed", op);
            end else begin
                e = sb8.pop_front();
                checks++;
                if (busy_cnt != 9 || bus8.busy !== 1'b0 || bus8.hi !== e[15:8] || bus8.lo !== e[7:0]) begin
                    errors++;
                    $display("FAIL narrow op%0d: busy cycles=%0d hi=%h lo=%h, required 9 hi=%h lo=%h",
                             op, busy_cnt, bus8.hi, bus8.lo, e[15:8], e[7:0]);
                end
                if (op == 0) begin
                    bus8.start = 1'b1; bus8.funct = F_DIVU; bus8.a = 8'd200; bus8.b = 8'd9;
                end
            end
        end
        @(negedge clk);
        checks++;
        if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
            errors++;
            $display("FAIL narrow_idle: done=%b busy=%b, required 0 0", bus8.done, bus8.busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus32.start = 1'b0; bus32.funct = 6'd0; bus32.a = 32'd0; bus32.b = 32'd0; bus32.cancel = 1'b0;
        bus8.start = 1'b0;  bus8.funct = 6'd0;  bus8.a = 8'd0;   bus8.b = 8'd0;   bus8.cancel = 1'b0;
        test_reset();
        test_multu_max();
        test_signed();
        test_div0();
        test_random();
        test_mthi();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb32.size() != 0 || sb8.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0", sb32.size(), sb8.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO registers. It sits beside the single-cycle ALU and its control decoder in the MIPS datapath, and executes the R-type funct group MULT, MULTU, DIV, DIVU, MTHI and MTLO. It is a parametrised, multi-cycle successor to the purely combinational ALU control path. It decodes the funct field itself and exposes a start/busy/done handshake, so the pipeline control stalls on `busy` instead of waiting on a fixed-latency ALU.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits. Must be ≥ 4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  request; sampled only when `busy`=0.
- `funct`  in  6  MIPS funct: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO.
- `a`  in  WIDTH  rs operand (dividend / multiplicand / MTHI, MTLO source).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `cancel`  in  1  pipeline flush; aborts an operation in flight.
- `busy`  out  1  operation in progress; the CPU stalls MF*/MT*/mult/div while high.
- `done`  out  1  one-cycle pulse when HI/LO have just been written by a mult/div.
- `hi`  out  WIDTH  HI register (MFHI reads it directly).
- `lo`  out  WIDTH  LO register (MFLO reads it directly).
- `div0`  out  1  last completed divide had divisor 0.

## Operation
- **States:** IDLE, RUN, FIX.
- **IDLE → RUN:** on `start` with a mult/div funct and `cancel`=0.
  - Latch the operation.
  - Latch |a| and |b| for signed ops; raw values for unsigned ops.
  - Latch the sign-correction bits. Load the counter with `WIDTH`-1. Clear `div0`.
- **IDLE, MTHI/MTLO:** on `start` with funct MTHI/MTLO, `hi` (or `lo`) <= `a` at that edge. No busy, no done.
- **IDLE, other funct:** `start` with any other funct is ignored.
- **RUN:** one radix-2 step per cycle.
  - Multiply: shift-add into a 2·`WIDTH` accumulator.
  - Divide: restoring shift-subtract.
  - The counter decrements each step; at 0, go to FIX.
- **FIX:** write the results, pulse `done`, return to IDLE.
  - Mult: {hi, lo} <= product, two's-complement negated if the signs differ (signed op only).
  - Div: lo <= quotient, negated if the operand signs differ; hi <= remainder, taking the sign of the dividend (signed op only).
  - Divisor 0: hi <= `a` as latched, lo <= all ones, `div0` <= 1. Latency is unchanged.
  - Signed most-negative / -1: lo = most-negative value (wrap), hi = 0. No flag is raised.
- **Cancel:**
  - `cancel` in RUN/FIX → IDLE at the next edge; hi, lo and `div0` are unchanged and there is no done.
  - `cancel` has priority over `start`: a start in the same cycle is dropped.
- **Start while busy:** ignored.
- **Reset (any state):** immediately sets state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, div0=0.

## Timing
- **Accept:** edge E0 samples `start`.
- **Busy:** `busy`=1 for exactly `WIDTH`+1 cycles after E0 (`WIDTH` RUN cycles plus 1 FIX cycle).
- **Completion:** edge E(`WIDTH`+1) writes hi/lo.
  - In the following cycle, `done`=1 and `busy`=0.
  - The new hi/lo values are visible in that same cycle.
  - Total latency is 33 cycles for `WIDTH`=32.
- **Back-to-back:** a `start` in the `done` cycle is accepted, so there is no dead cycle between operations.
- **MTHI/MTLO:** one-edge latency; the new value is visible the cycle after `start`.
- **Outputs:** all outputs are registered except `busy`, which is decoded from state (busy = state≠IDLE).

## Test plan
1. **MULTU max × max:** `WIDTH`=32, MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → busy for 33 cycles, then done for 1 cycle; hi=0xFFFFFFFE, lo=0x00000001.
2. **Signed multiply and divide:**
   - MULT a=-3, b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
   - DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
3. **Divide by zero:** DIVU a=5, b=0 → after 33 cycles lo=0xFFFFFFFF, hi=5, div0=1. The next MULTU 2×3 clears div0 at accept; result hi=0, lo=6.
4. **Cancel, ignored start, MTHI:**
   - MULT 0x1234×0x10 cancelled on its 10th busy cycle → busy=0 next cycle; hi/lo keep their prior values; done never pulses.
   - A `start` pulsed mid-operation is ignored.
   - MTHI a=0x1234 while idle → hi=0x1234 one cycle later; busy stays 0.
5. **Reset mid-operation:** `rst_n` low during cycle 20 of a DIVU → hi=lo=0, busy=done=div0=0 without waiting for a clock edge. After release, a new DIVU 100/7 → lo=14, hi=2.
6. **Narrow width, back-to-back:** `WIDTH`=8 instance, MULT a=0x80, b=0x80 → busy for 9 cycles; hi=0x40, lo=0x00. A second start in the done cycle (DIVU 200/9) → lo=22, hi=2 exactly 9 cycles later.
